// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module  : dmem_arbiter_pkg
//  Brief   : Shared types for the fetch/data memory-port arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    typedef logic [31:0] Addr;
    typedef logic [31:0] UIntX;

    // Access size encoding of the memory unit
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } MemSize;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module  : dmem_arbiter_if
//  Brief   : Requester and memory-side bus of the arbiter; slave = arbiter view.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp_valid;

    logic              d_valid;
    logic              d_ready;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_wmask;
    logic              d_resp_valid;

    logic [DATA_W-1:0] resp_rdata;

    logic              m_valid;
    logic              m_ready;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_wmask;
    logic              m_resp_valid;
    logic [DATA_W-1:0] m_resp_rdata;

    modport master (
        output i_valid, i_addr, d_valid, d_wen, d_addr, d_wdata, d_wmask,
               m_ready, m_resp_valid, m_resp_rdata,
        input  i_ready, i_resp_valid, d_ready, d_resp_valid, resp_rdata,
               m_valid, m_wen, m_addr, m_wdata, m_wmask
    );

    modport slave (
        input  i_valid, i_addr, d_valid, d_wen, d_addr, d_wdata, d_wmask,
               m_ready, m_resp_valid, m_resp_rdata,
        output i_ready, i_resp_valid, d_ready, d_resp_valid, resp_rdata,
               m_valid, m_wen, m_addr, m_wdata, m_wmask
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_pick2.sv
// ============================================================================
//  Module  : arb_pick2
//  Brief   : Two-input winner picker; round-robin on ties when
//            DMEM_ARB_ROUND_ROBIN_EN is defined, else data side wins ties.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic   i_req_i,
    input  logic   i_req_d,
    input  owner_t i_last,
    output owner_t o_win
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_win = OWN_D;
        if (i_req_i && i_req_d) begin
            if (i_last == OWN_D) o_win = OWN_I;
            else                 o_win = OWN_D;
        end else if (i_req_i) begin
            o_win = OWN_I;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = (i_last == OWN_D);

    always_comb begin
        o_win = OWN_D;
        if (i_req_i && !i_req_d) o_win = OWN_I;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module  : dmem_arbiter
//  Brief   : Shares one memory port between fetch and data requesters, one
//            transaction in flight. Option macro: DMEM_ARB_ROUND_ROBIN_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    state_t r_state;
    owner_t r_owner;
    owner_t r_last;
    owner_t w_pick;
    owner_t w_sel;
    logic   w_cmd_phase;
    logic   w_sel_valid;
    logic   w_sel_wen;
    logic   w_m_valid;
    logic   w_acc;
    logic   w_resp_ok;

    arb_pick2 u_pick (
        .i_req_i (bus.i_valid),
        .i_req_d (bus.d_valid),
        .i_last  (r_last),
        .o_win   (w_pick)
    );

    // Once a command is stalled the grant is frozen on the recorded owner
    always_comb begin
        w_sel = w_pick;
        if (r_state == HOLD) w_sel = r_owner;
    end

    assign w_cmd_phase = !reset && (r_state != WAIT_RESP);
    assign w_sel_valid = (w_sel == OWN_I) ? bus.i_valid : bus.d_valid;
    assign w_sel_wen   = (w_sel == OWN_D) && bus.d_wen;
    assign w_m_valid   = w_cmd_phase && w_sel_valid;
    assign w_acc       = w_m_valid && bus.m_ready;
    assign w_resp_ok   = !reset && (r_state == WAIT_RESP) && bus.m_resp_valid;

    assign bus.m_valid = w_m_valid;
    assign bus.m_wen   = w_cmd_phase && w_sel_wen;
    assign bus.m_addr  = !w_cmd_phase ? {ADDR_W{1'b0}} :
                         (w_sel == OWN_I) ? bus.i_addr : bus.d_addr;
    assign bus.m_wdata = (!w_cmd_phase || (w_sel == OWN_I)) ? {DATA_W{1'b0}} : bus.d_wdata;
    assign bus.m_wmask = !w_cmd_phase ? 2'b00 :
                         (w_sel == OWN_I) ? SIZE_W : bus.d_wmask;

    assign bus.i_ready = w_acc && (w_sel == OWN_I);
    assign bus.d_ready = w_acc && (w_sel == OWN_D);

    assign bus.i_resp_valid = w_resp_ok && (r_owner == OWN_I);
    assign bus.d_resp_valid = w_resp_ok && (r_owner == OWN_D);
    assign bus.resp_rdata   = bus.m_resp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_D;
            r_last  <= OWN_D;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_acc) begin
                        r_last  <= w_sel;
                        r_owner <= w_sel;
                        r_state <= w_sel_wen ? IDLE : WAIT_RESP;
                    end else if (w_m_valid) begin
                        r_owner <= w_sel;
                        r_state <= HOLD;
                    end
                end
                WAIT_RESP: begin
                    if (bus.m_resp_valid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Brief   : Self-checking bench for dmem_arbiter (vector table + scoreboards).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        is_i;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic        iv;
        logic        dv;
        logic        dwen;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [1:0]  dwmask;
        logic        mready;
        logic        e_mvalid;
        logic        e_iready;
        logic        e_dready;
        logic        chk_f;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_wmask;
    } vec_t;

    rd_exp_t rd_q[$];
    bit      grant_q[$];
    vec_t    vecs[6];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        bus.i_valid = 1'b0; bus.i_addr = '0;
        bus.d_valid = 1'b0; bus.d_wen = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0;   bus.d_wmask = '0;
        bus.m_ready = 1'b0;
    endtask

    // Memory answers the oldest outstanding read; owner and data come from the scoreboard
    task automatic respond(input string tag);
        rd_exp_t e;
        if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no outstanding read expected", tag);
            return;
        end
        e = rd_q.pop_front();
        bus.m_resp_valid = 1'b1;
        bus.m_resp_rdata = e.data;
        #1;
        check({tag, "_i_resp"}, bus.i_resp_valid, e.is_i);
        check({tag, "_d_resp"}, bus.d_resp_valid, !e.is_i);
        check({tag, "_rdata"},  bus.resp_rdata, e.data);
        check({tag, "_rdy_blk"}, {bus.i_ready, bus.d_ready, bus.m_valid}, 3'b000);
        tick();
        bus.m_resp_valid = 1'b0;
        bus.m_resp_rdata = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        logic  win_i;
        logic  is_rd;
        t = $sformatf("vec%0d", idx);
        bus.i_valid = v.iv;  bus.i_addr = v.iaddr;
        bus.d_valid = v.dv;  bus.d_wen = v.dwen; bus.d_addr = v.daddr;
        bus.d_wdata = v.dwdata; bus.d_wmask = v.dwmask;
        bus.m_ready = v.mready;
        #1;
        check({t, "_m_valid"}, bus.m_valid, v.e_mvalid);
        check({t, "_i_ready"}, bus.i_ready, v.e_iready);
        check({t, "_d_ready"}, bus.d_ready, v.e_dready);
        if (v.chk_f) begin
            check({t, "_m_addr"},  bus.m_addr,  v.e_addr);
            check({t, "_m_wen"},   bus.m_wen,   v.e_wen);
            check({t, "_m_wdata"}, bus.m_wdata, v.e_wdata);
            check({t, "_m_wmask"}, bus.m_wmask, v.e_wmask);
        end
        win_i = v.iv && !v.dv;
        is_rd = win_i || !v.dwen;
        if (v.e_mvalid) begin
            if (!v.mready) begin
                tick();
                bus.m_ready = 1'b1;
                #1;
                check({t, "_hold_acc"}, {bus.i_ready, bus.d_ready}, {win_i, !win_i});
                check({t, "_hold_addr"}, bus.m_addr, v.e_addr);
            end
            if (is_rd) rd_q.push_back('{is_i: win_i, data: mdata(v.e_addr)});
            tick();
            clear_cmds();
            if (is_rd) respond(t);
        end else begin
            tick();
            clear_cmds();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_cmds();
        bus.m_resp_valid = 1'b0;
        bus.m_resp_rdata = '0;

        //                iv  dv  wen iaddr          daddr          dwdata         msk   mrdy  mv  ir  dr  chk wen e_addr         e_wdata        e_msk
        vecs[0] = '{1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        32'h0,         2'd0, 1'b1, 1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000_0100,32'h0,        2'd2};
        vecs[1] = '{1'b0,1'b1,1'b1,32'h0,        32'h0000_0200,32'h0000_0055, 2'd2, 1'b1, 1'b1,1'b0,1'b1,1'b1,1'b1,32'h0000_0200,32'h0000_0055,2'd2};
        vecs[2] = '{1'b0,1'b1,1'b0,32'h0,        32'h0000_0300,32'h0000_1234, 2'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0300,32'h0000_1234,2'd0};
        vecs[3] = '{1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        32'h0000_FFFF, 2'd3, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0104,32'h0,        2'd2};
        vecs[4] = '{1'b0,1'b0,1'b0,32'h0000_0108,32'h0,        32'h0,         2'd0, 1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        2'd0};
        vecs[5] = '{1'b0,1'b1,1'b1,32'h0,        32'h0000_0204,32'hA5A5_A5A5, 2'd1, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,32'h0000_0204,32'hA5A5_A5A5,2'd1};

        // Outputs held quiet while reset is asserted, even with requests pending
        tick();
        bus.i_valid = 1'b1; bus.i_addr = 32'h40; bus.d_valid = 1'b1; bus.d_addr = 32'h80;
        bus.m_ready = 1'b1;
        #1;
        check("rst_outputs", {bus.m_valid, bus.i_ready, bus.d_ready, bus.i_resp_valid, bus.d_resp_valid}, 5'b0);
        check("rst_fields", {bus.m_wen, bus.m_addr, bus.m_wdata, bus.m_wmask}, 67'b0);
        tick();
        clear_cmds();
        reset = 1'b0;
        #1;
        check("rst_state", dut.r_state, IDLE);
        check("rst_owner", dut.r_owner, OWN_D);
        tick();

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Fetch read alone, response three cycles after acceptance
        bus.i_valid = 1'b1; bus.i_addr = 32'h100; bus.m_ready = 1'b1;
        #1;
        check("fr_m_addr", bus.m_addr, 32'h100);
        check("fr_i_ready", bus.i_ready, 1'b1);
        rd_q.push_back('{is_i: 1'b1, data: 32'hDEAD_BEEF});
        tick();
        clear_cmds();
        for (int c = 1; c < 3; c++) begin
            #1;
            check($sformatf("fr_wait%0d_resp", c), {bus.i_resp_valid, bus.d_resp_valid}, 2'b00);
            tick();
        end
        respond("fr_resp");

        // Stall and hold: a stalled store keeps the grant while fetch waits
        bus.d_valid = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'h55; bus.d_wmask = 2'd2; bus.m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin bus.i_valid = 1'b1; bus.i_addr = 32'h180; end
            #1;
            check($sformatf("sh_c%0d_addr", c), bus.m_addr, 32'h200);
            check($sformatf("sh_c%0d_rdy", c), {bus.i_ready, bus.d_ready, bus.m_valid}, 3'b001);
            tick();
        end
        bus.m_ready = 1'b1;
        #1;
        check("sh_c4_rdy", {bus.i_ready, bus.d_ready}, 2'b01);
        tick();
        bus.d_valid = 1'b0; bus.d_wen = 1'b0;
        #1;
        check("sh_c5_i_ready", bus.i_ready, 1'b1);
        check("sh_c5_addr", bus.m_addr, 32'h180);
        rd_q.push_back('{is_i: 1'b1, data: mdata(32'h180)});
        tick();
        clear_cmds();
        respond("sh_resp");

        // Tie: last grant was fetch
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        grant_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        bus.i_valid = 1'b1; bus.i_addr = 32'h400;
        bus.d_valid = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h500;
        bus.d_wdata = 32'h77; bus.d_wmask = 2'd2; bus.m_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            bit exp_i;
            exp_i = grant_q.pop_front();
            #1;
            check($sformatf("tie%0d_grant", g), {bus.i_ready, bus.d_ready}, {exp_i, !exp_i});
            if (exp_i) begin
                rd_q.push_back('{is_i: 1'b1, data: mdata(32'h400)});
                tick();
                respond($sformatf("tie%0d", g));
            end else begin
                tick();
            end
        end
        clear_cmds();
        tick();

        // Outstanding data read blocks fetch until after its response
        bus.d_valid = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h300; bus.d_wmask = 2'd2;
        bus.i_valid = 1'b1; bus.i_addr = 32'h108; bus.m_ready = 1'b1;
        #1;
        check("ob_d_ready", {bus.i_ready, bus.d_ready}, 2'b01);
        rd_q.push_back('{is_i: 1'b0, data: mdata(32'h300)});
        tick();
        bus.d_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("ob_wait%0d", c), {bus.i_ready, bus.m_valid}, 2'b00);
            tick();
        end
        respond("ob_dresp");
        #1;
        check("ob_i_ready", bus.i_ready, 1'b1);
        check("ob_i_addr", bus.m_addr, 32'h108);
        rd_q.push_back('{is_i: 1'b1, data: mdata(32'h108)});
        tick();
        clear_cmds();
        respond("ob_iresp");

        // Spurious response in IDLE
        bus.m_resp_valid = 1'b1; bus.m_resp_rdata = 32'h1111_2222;
        #1;
        check("sp_resp", {bus.i_resp_valid, bus.d_resp_valid}, 2'b00);
        tick();
        bus.m_resp_valid = 1'b0;

        // Reset while a read is outstanding drops the late response
        bus.d_valid = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h600; bus.m_ready = 1'b1;
        #1;
        check("rw_d_ready", bus.d_ready, 1'b1);
        tick();
        clear_cmds();
        reset = 1'b1;
        #1;
        check("rw_rst_out", {bus.m_valid, bus.i_ready, bus.d_ready}, 3'b000);
        tick();
        reset = 1'b0;
        bus.m_resp_valid = 1'b1; bus.m_resp_rdata = 32'h3333_4444;
        #1;
        check("rw_resp", {bus.i_resp_valid, bus.d_resp_valid}, 2'b00);
        check("rw_state", dut.r_state, IDLE);
        check("rw_owner", dut.r_owner, OWN_D);
        tick();
        bus.m_resp_valid = 1'b0;

        if (rd_q.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: %0d reads left, expected 0", rd_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-to-one arbiter sharing the single memory-unit port between the instruction-fetch requester and the MemoryStage data requester. It sits between the core pipeline and the memory unit. It selects one requester, holds that grant stable until the memory accepts the command, and tracks one outstanding read so the response is returned only to its owner. One transaction is in flight at a time.

## Interface
Parameters:
- ADDR_W, 32, address width (Addr)
- DATA_W, 32, data width (UIntX)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid / i_ready  in / out  1 / 1  fetch command handshake
- i_addr  in  ADDR_W  fetch address; fetch commands are always reads
- i_resp_valid  out  1  fetch read data valid
- d_valid / d_ready  in / out  1 / 1  data command handshake
- d_wen  in  1  1 = store
- d_addr, d_wdata  in  ADDR_W, DATA_W  data address and store data
- d_wmask  in  2  MemSize
- d_resp_valid  out  1  data read data valid
- resp_rdata  out  DATA_W  read data, broadcast to both requesters
- m_valid / m_ready  out / in  1 / 1  memory command handshake
- m_wen, m_addr, m_wdata, m_wmask  out  1, ADDR_W, DATA_W, 2  memory command fields
- m_resp_valid, m_resp_rdata  in  1, DATA_W  memory read response

## Operation
- State machine states:
  - IDLE: no grant held.
  - HOLD: grant locked, command presented but not yet accepted.
  - WAIT_RESP: read accepted, response pending.
- Registers: `owner` (I or D), `last` (the round-robin pointer, meaning the last requester granted).
- IDLE selection:
  - If only one requester is valid, it wins.
  - If both are valid, priority is set by the configuration macro.
  - The winner's fields drive the m_* outputs combinationally, and m_valid = the winner's valid.
- Acceptance is the cycle in which m_valid && m_ready:
  - The winner's x_ready = m_ready; the loser's ready = 0.
  - Store accepted: go to IDLE.
  - Read accepted: go to WAIT_RESP, with owner = winner.
  - Not accepted (m_ready = 0): go to HOLD, with owner = winner.
- HOLD:
  - m_* are driven from owner's inputs; the requester must keep valid and fields stable.
  - The other requester's ready stays 0 even if it becomes valid.
  - On acceptance, the next state is the same as for an acceptance in IDLE.
- WAIT_RESP:
  - m_valid = 0, and both readies are 0.
  - On m_resp_valid: owner's resp_valid = 1 in the same cycle, then go to IDLE.
- Fetch commands drive m_wen = 0, m_wdata = 0 and m_wmask = SIZE_W.
- resp_rdata = m_resp_rdata at all times.
- Each x_resp_valid is asserted only in WAIT_RESP and only for the owner.
- A spurious m_resp_valid in IDLE or HOLD is ignored and not forwarded.
- `last` is updated to the winner on every accepted command.

## Timing
- Reset values:
  - state = IDLE, owner = D, last = D.
  - All ready, valid and resp_valid outputs are 0; m_* fields are 0.
- Command latency:
  - 0 cycles from x_valid to m_valid when IDLE.
  - Accepted in the same cycle if m_ready = 1.
- Read: x_resp_valid is combinational with m_resp_valid.
- Bubbles:
  - IDLE is re-entered the cycle after a response, so there is a minimum of 1 bubble between a read response and the next command.
  - Stores can be issued back to back, with zero bubbles.
- Reset mid-operation (HOLD or WAIT_RESP): return to IDLE next cycle. A memory response arriving after reset is dropped.
- Simultaneous requests: both valid in the same IDLE cycle → exactly one ready is high.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the requester other than `last` wins, so the grants alternate.
- DMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, D always wins ties; `last` is still maintained but unused.

## Structure
- Shared package holds:
  - the state enum (IDLE, HOLD, WAIT_RESP)
  - the owner enum (OWN_I, OWN_D)
  - the existing MemSize / SIZE_W constants
  - Addr and UIntX
- One sub-module, `arb_pick2`: a combinational two-input priority/round-robin picker taking valids and `last` and producing the winner. It is the only logic affected by the macro.

## Test plan
- Fetch read alone: i_valid = 1, i_addr = 0x100, m_ready = 1 → m_addr = 0x100 and i_ready = 1 in cycle 0; m_resp_valid with 0xDEADBEEF in cycle 3 → i_resp_valid = 1 and resp_rdata = 0xDEADBEEF in cycle 3, d_resp_valid = 0.
- Stall and hold: d_valid store to 0x200 with wdata 0x55, m_ready = 0 for 4 cycles; i_valid rises in cycle 1 → m_addr stays 0x200 and i_ready = 0 throughout; m_ready = 1 in cycle 4 → d_ready = 1, then IDLE, and fetch is granted in cycle 5.
- Tie, with and without the macro: both valid for 4 consecutive accepted stores → macro defined: grant order D, I, D, I; macro undefined: D, D, D, D.
- Outstanding read blocks: a data read is accepted and a fetch request waits → i_ready = 0 until one cycle after m_resp_valid; the fetch is accepted the next cycle.
- Spurious response: m_resp_valid = 1 in IDLE → both resp_valid = 0.
- Reset in WAIT_RESP: reset for 1 cycle, then m_resp_valid → no resp_valid is asserted; state = IDLE and owner = D.
